// File: rtl/wb_buffer_pkg.sv
// Shared types and sizing for the per-cache writeback buffer.
package wb_buffer_pkg;

   localparam int unsigned XLEN             = 32;
   localparam int unsigned CACHELINE_SIZE   = 512;
   localparam int unsigned LINE_OFFSET_BITS = $clog2(CACHELINE_SIZE / 8);
   localparam int unsigned LINE_W           = XLEN - LINE_OFFSET_BITS;

   typedef struct packed {
      logic                      valid;
      logic [XLEN-1:0]           addr;
      logic [CACHELINE_SIZE-1:0] data;
   } wb_entry_t;

   typedef enum logic {
      WB_IDLE  = 1'b0,
      WB_ISSUE = 1'b1
   } wb_state_t;

   function automatic logic [LINE_W-1:0] line_of(input logic [XLEN-1:0] addr);
      return addr[XLEN-1:LINE_OFFSET_BITS];
   endfunction

endpackage

// File: rtl/wb_buffer_match.sv
// Youngest-first line-address CAM over the buffer entries; reports the newest valid match.
module wb_match
   import wb_buffer_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic [DEPTH-1:0]         i_valid,
   input  logic [LINE_W-1:0]        i_lines [DEPTH],
   input  logic [$clog2(DEPTH)-1:0] i_tail,
   input  logic [LINE_W-1:0]        i_key,
   output logic                     o_hit,
   output logic [$clog2(DEPTH)-1:0] o_idx
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   logic [PTR_W-1:0] w_pos;

   // Walk backwards from the newest slot so the first hit is the youngest copy.
   always_comb begin
      o_hit = 1'b0;
      o_idx = '0;
      w_pos = '0;
      for (int k = 0; k < DEPTH; k++) begin
         w_pos = i_tail - PTR_W'(k + 1);
         if (!o_hit && i_valid[w_pos] && (i_lines[w_pos] == i_key)) begin
            o_hit = 1'b1;
            o_idx = w_pos;
         end
      end
   end

endmodule

// File: rtl/wb_buffer.sv
// Writeback buffer: in-order drain of evicted dirty lines with coalescing and snoop lookup.
// Optional statistics outputs are enabled by defining WB_BUFFER_STATS_EN.
module wb_buffer
   import wb_buffer_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned ID    = 0
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      push_valid,
   output logic                      push_ready,
   input  logic [XLEN-1:0]           push_addr,
   input  logic [CACHELINE_SIZE-1:0] push_data,
   output logic                      mem_req,
   output logic [XLEN-1:0]           mem_addr,
   output logic [CACHELINE_SIZE-1:0] mem_wdata,
   input  logic                      mem_ack,
   input  logic                      snoop_valid,
   input  logic [XLEN-1:0]           snoop_addr,
   output logic                      snoop_hit,
   output logic [CACHELINE_SIZE-1:0] snoop_data,
   output logic [$clog2(DEPTH):0]    count,
   output logic                      empty
`ifdef WB_BUFFER_STATS_EN
   ,
   output logic [31:0]               stat_pushes,
   output logic [31:0]               stat_coalesces,
   output logic [$clog2(DEPTH):0]    stat_hwm
`endif
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   wb_entry_t                 r_entries [DEPTH];
   logic [PTR_W-1:0]          r_head;
   logic [PTR_W-1:0]          r_tail;
   logic [CNT_W-1:0]          r_count;
   wb_state_t                 r_state;
   logic                      r_mem_req;
   logic [XLEN-1:0]           r_mem_addr;
   logic [CACHELINE_SIZE-1:0] r_mem_wdata;

   logic [DEPTH-1:0]          w_valid;
   logic [LINE_W-1:0]         w_lines [DEPTH];
   logic                      w_push_hit;
   logic [PTR_W-1:0]          w_push_idx;
   logic                      w_snp_hit;
   logic [PTR_W-1:0]          w_snp_idx;
   logic                      w_coalesce;
   logic                      w_push;
   logic                      w_alloc;
   logic                      w_pop;
   logic                      w_fwd;
   logic [PTR_W-1:0]          w_head_nxt;
   logic [CNT_W-1:0]          w_count_nxt;
   logic                      w_unused_snoop_lsb;

   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         w_valid[i] = r_entries[i].valid;
         w_lines[i] = line_of(r_entries[i].addr);
      end
   end

   wb_match #(.DEPTH(DEPTH)) u_push_match (
      .i_valid (w_valid),
      .i_lines (w_lines),
      .i_tail  (r_tail),
      .i_key   (line_of(push_addr)),
      .o_hit   (w_push_hit),
      .o_idx   (w_push_idx)
   );

   wb_match #(.DEPTH(DEPTH)) u_snoop_match (
      .i_valid (w_valid),
      .i_lines (w_lines),
      .i_tail  (r_tail),
      .i_key   (line_of(snoop_addr)),
      .o_hit   (w_snp_hit),
      .o_idx   (w_snp_idx)
   );

   // The in-flight head is never a coalesce target; the head is the oldest, so a youngest hit on it means no other copy.
   assign w_coalesce  = (r_state == WB_ISSUE) && w_push_hit && (w_push_idx != r_head);
   assign push_ready  = (r_count < CNT_W'(DEPTH)) || w_coalesce;
   assign w_push      = push_valid && push_ready;
   assign w_alloc     = w_push && !w_coalesce;
   assign w_pop       = (r_state == WB_ISSUE) && mem_ack;
   assign w_head_nxt  = r_head + PTR_W'(1);
   assign w_fwd       = w_push && w_coalesce && (w_push_idx == w_head_nxt);

   always_comb begin
      w_count_nxt = r_count;
      case ({w_alloc, w_pop})
         2'b10:   w_count_nxt = r_count + CNT_W'(1);
         2'b01:   w_count_nxt = r_count - CNT_W'(1);
         default: w_count_nxt = r_count;
      endcase
   end

   assign snoop_hit          = snoop_valid && w_snp_hit;
   assign snoop_data         = snoop_hit ? r_entries[w_snp_idx].data : '0;
   assign w_unused_snoop_lsb = ^snoop_addr[LINE_OFFSET_BITS-1:0];

   // Entry storage and FIFO pointers.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_entries[i] <= '0;
         end
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            if (w_coalesce) begin
               r_entries[w_push_idx].data <= push_data;
            end else begin
               r_entries[r_tail] <= '{valid: 1'b1, addr: push_addr, data: push_data};
               r_tail            <= r_tail + PTR_W'(1);
            end
         end
         if (w_pop) begin
            r_entries[r_head].valid <= 1'b0;
            r_head                  <= w_head_nxt;
         end
         r_count <= w_count_nxt;
      end
   end

   // Drain FSM; the next head is forwarded if it is being coalesced on the ack cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= WB_IDLE;
         r_mem_req   <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
      end else begin
         case (r_state)
            WB_IDLE: begin
               if (r_count != '0) begin
                  r_state     <= WB_ISSUE;
                  r_mem_req   <= 1'b1;
                  r_mem_addr  <= r_entries[r_head].addr;
                  r_mem_wdata <= r_entries[r_head].data;
               end
            end
            WB_ISSUE: begin
               if (mem_ack) begin
                  if (r_count > CNT_W'(1)) begin
                     r_mem_addr  <= r_entries[w_head_nxt].addr;
                     r_mem_wdata <= w_fwd ? push_data : r_entries[w_head_nxt].data;
                  end else begin
                     r_state   <= WB_IDLE;
                     r_mem_req <= 1'b0;
                  end
               end
            end
            default: begin
               r_state   <= WB_IDLE;
               r_mem_req <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         assert (!(mem_ack && (r_state == WB_IDLE)))
            else $error("wb_buffer[%0d]: mem_ack received while drain is idle", ID);
      end
   end

   assign mem_req   = r_mem_req;
   assign mem_addr  = r_mem_addr;
   assign mem_wdata = r_mem_wdata;
   assign count     = r_count;
   assign empty     = (r_count == '0);

`ifdef WB_BUFFER_STATS_EN
   logic [31:0]      r_stat_pushes;
   logic [31:0]      r_stat_coalesces;
   logic [CNT_W-1:0] r_stat_hwm;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_stat_pushes    <= '0;
         r_stat_coalesces <= '0;
         r_stat_hwm       <= '0;
      end else begin
         if (w_push) begin
            r_stat_pushes <= r_stat_pushes + 32'd1;
         end
         if (w_push && w_coalesce) begin
            r_stat_coalesces <= r_stat_coalesces + 32'd1;
         end
         if (w_count_nxt > r_stat_hwm) begin
            r_stat_hwm <= w_count_nxt;
         end
      end
   end

   assign stat_pushes    = r_stat_pushes;
   assign stat_coalesces = r_stat_coalesces;
   assign stat_hwm       = r_stat_hwm;
`endif

endmodule

// File: tb/tb_wb_buffer.sv
// Directed self-checking bench for wb_buffer (DEPTH=4); stats checks apply when WB_BUFFER_STATS_EN is defined.
module tb_wb_buffer;
   import wb_buffer_pkg::*;

   typedef logic [CACHELINE_SIZE-1:0] line_t;

   logic          clk;
   logic          rst;
   logic          push_valid;
   logic          push_ready;
   logic [XLEN-1:0] push_addr;
   line_t         push_data;
   logic          mem_req;
   logic [XLEN-1:0] mem_addr;
   line_t         mem_wdata;
   logic          mem_ack;
   logic          snoop_valid;
   logic [XLEN-1:0] snoop_addr;
   logic          snoop_hit;
   line_t         snoop_data;
   logic [2:0]    count;
   logic          empty;
`ifdef WB_BUFFER_STATS_EN
   logic [31:0]   stat_pushes;
   logic [31:0]   stat_coalesces;
   logic [2:0]    stat_hwm;
`endif

   int n_checks = 0;
   int n_errors = 0;

   wb_buffer #(.DEPTH(4), .ID(0)) dut (
      .clk         (clk),
      .rst         (rst),
      .push_valid  (push_valid),
      .push_ready  (push_ready),
      .push_addr   (push_addr),
      .push_data   (push_data),
      .mem_req     (mem_req),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_ack     (mem_ack),
      .snoop_valid (snoop_valid),
      .snoop_addr  (snoop_addr),
      .snoop_hit   (snoop_hit),
      .snoop_data  (snoop_data),
      .count       (count),
      .empty       (empty)
`ifdef WB_BUFFER_STATS_EN
      ,
      .stat_pushes    (stat_pushes),
      .stat_coalesces (stat_coalesces),
      .stat_hwm       (stat_hwm)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic line_t ld(input logic [31:0] k);
      return {(CACHELINE_SIZE / 32){k}};
   endfunction

   task automatic check(input string tag, input line_t got, input line_t exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input string tag, input logic [XLEN-1:0] a, input line_t d);
      push_valid = 1'b1;
      push_addr  = a;
      push_data  = d;
      #1;
      check({tag, "_ready"}, line_t'(push_ready), line_t'(1));
      tick();
      push_valid = 1'b0;
   endtask

   task automatic wait_req(input string tag);
      int n = 0;
      while (!mem_req && n < 10) begin
         tick();
         n++;
      end
      check({tag, "_req"}, line_t'(mem_req), line_t'(1));
   endtask

   task automatic drain_one(input string tag, input logic [XLEN-1:0] a, input line_t d);
      wait_req(tag);
      check({tag, "_addr"}, line_t'(mem_addr), line_t'(a));
      check({tag, "_data"}, mem_wdata, d);
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
   endtask

   initial begin
      rst = 1'b1; push_valid = 1'b0; push_addr = '0; push_data = '0;
      mem_ack = 1'b0; snoop_valid = 1'b0; snoop_addr = '0;
      tick(); tick(); tick();
      rst = 1'b0;

      // Reset state
      snoop_valid = 1'b1; snoop_addr = 32'h0;
      #1;
      check("rst_count", line_t'(count), line_t'(0));
      check("rst_empty", line_t'(empty), line_t'(1));
      check("rst_req", line_t'(mem_req), line_t'(0));
      check("rst_addr", line_t'(mem_addr), line_t'(0));
      check("rst_wdata", mem_wdata, line_t'(0));
      check("rst_snoop_hit", line_t'(snoop_hit), line_t'(0));
      check("rst_snoop_data", snoop_data, line_t'(0));
      check("rst_ready", line_t'(push_ready), line_t'(1));
      snoop_valid = 1'b0;

      // Single drain with a 3-cycle memory latency
      push("t1_push", 32'h100, ld(32'hD1));
      check("t1_count", line_t'(count), line_t'(1));
      check("t1_req_lat1", line_t'(mem_req), line_t'(0));
      tick();
      check("t1_req_lat2", line_t'(mem_req), line_t'(1));
      check("t1_addr", line_t'(mem_addr), line_t'(32'h100));
      tick(); tick();
      check("t1_hold_addr", line_t'(mem_addr), line_t'(32'h100));
      check("t1_hold_data", mem_wdata, ld(32'hD1));
      drain_one("t1_drain", 32'h100, ld(32'hD1));
      check("t1_empty", line_t'(empty), line_t'(1));
      check("t1_req_off", line_t'(mem_req), line_t'(0));

      // Fill, stall, then free one slot
      push("t2_p0", 32'h100, ld(32'h11));
      push("t2_p1", 32'h140, ld(32'h12));
      push("t2_p2", 32'h180, ld(32'h13));
      push("t2_p3", 32'h1C0, ld(32'h14));
      check("t2_full_count", line_t'(count), line_t'(4));
      check("t2_head_addr", line_t'(mem_addr), line_t'(32'h100));
      push_valid = 1'b1; push_addr = 32'h200; push_data = ld(32'h15);
      #1;
      check("t2_stall", line_t'(push_ready), line_t'(0));
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      check("t2_pop_count", line_t'(count), line_t'(3));
      check("t2_freed", line_t'(push_ready), line_t'(1));
      tick();
      push_valid = 1'b0;
      check("t2_refill_count", line_t'(count), line_t'(4));
      drain_one("t2_d1", 32'h140, ld(32'h12));
      drain_one("t2_d2", 32'h180, ld(32'h13));
      drain_one("t2_d3", 32'h1C0, ld(32'h14));
      drain_one("t2_d4", 32'h200, ld(32'h15));
      check("t2_empty", line_t'(empty), line_t'(1));

      // Coalesce behind an in-flight head; re-push of the head allocates
      push("t3_p0", 32'h100, ld(32'h21));
      wait_req("t3_inflight");
      push("t3_p1", 32'h140, ld(32'h22));
      push("t3_p2", 32'h140, ld(32'h23));
      check("t3_coal_count", line_t'(count), line_t'(2));
      push("t3_p3", 32'h100, ld(32'h24));
      check("t3_alloc_count", line_t'(count), line_t'(3));
      snoop_valid = 1'b1; snoop_addr = 32'h108;
      #1;
      check("t3_snoop_hit", line_t'(snoop_hit), line_t'(1));
      check("t3_snoop_young", snoop_data, ld(32'h24));
      snoop_valid = 1'b0;
      drain_one("t3_d0", 32'h100, ld(32'h21));
      drain_one("t3_d1", 32'h140, ld(32'h23));
      drain_one("t3_d2", 32'h100, ld(32'h24));
      check("t3_empty", line_t'(empty), line_t'(1));

      // Snoop hit, miss, and same-cycle push invisibility
      push("t4_p0", 32'h180, ld(32'hD3));
      snoop_valid = 1'b1; snoop_addr = 32'h184;
      #1;
      check("t4_hit", line_t'(snoop_hit), line_t'(1));
      check("t4_data", snoop_data, ld(32'hD3));
      snoop_addr = 32'h200;
      #1;
      check("t4_miss", line_t'(snoop_hit), line_t'(0));
      snoop_addr = 32'h1C0;
      push_valid = 1'b1; push_addr = 32'h1C0; push_data = ld(32'hD4);
      #1;
      check("t4_same_cycle", line_t'(snoop_hit), line_t'(0));
      tick();
      push_valid = 1'b0;
      check("t4_after_push", line_t'(snoop_hit), line_t'(1));
      check("t4_after_data", snoop_data, ld(32'hD4));
      snoop_valid = 1'b0;
      drain_one("t4_d0", 32'h180, ld(32'hD3));
      drain_one("t4_d1", 32'h1C0, ld(32'hD4));

      // Coalescing push into the next head on the same cycle as ack at full
      push("t5_p0", 32'h100, ld(32'h31));
      push("t5_p1", 32'h140, ld(32'h32));
      push("t5_p2", 32'h180, ld(32'h33));
      push("t5_p3", 32'h1C0, ld(32'h34));
      wait_req("t5_inflight");
      check("t5_full", line_t'(count), line_t'(4));
      push_valid = 1'b1; push_addr = 32'h140; push_data = ld(32'h35);
      mem_ack = 1'b1;
      #1;
      check("t5_ready", line_t'(push_ready), line_t'(1));
      tick();
      push_valid = 1'b0; mem_ack = 1'b0;
      check("t5_count", line_t'(count), line_t'(3));
      drain_one("t5_d0", 32'h140, ld(32'h35));
      drain_one("t5_d1", 32'h180, ld(32'h33));
      drain_one("t5_d2", 32'h1C0, ld(32'h34));

      // Reset in the middle of a drain
      push("t6_p0", 32'h100, ld(32'h41));
      push("t6_p1", 32'h140, ld(32'h42));
      push("t6_p2", 32'h180, ld(32'h43));
      wait_req("t6_inflight");
      check("t6_count", line_t'(count), line_t'(3));
`ifdef WB_BUFFER_STATS_EN
      check("t6_stat_pushes", line_t'(stat_pushes), line_t'(20));
      check("t6_stat_coal", line_t'(stat_coalesces), line_t'(2));
      check("t6_stat_hwm", line_t'(stat_hwm), line_t'(4));
`endif
      rst = 1'b1;
      tick();
      check("t6_rst_count", line_t'(count), line_t'(0));
      check("t6_rst_req", line_t'(mem_req), line_t'(0));
`ifdef WB_BUFFER_STATS_EN
      check("t6_rst_pushes", line_t'(stat_pushes), line_t'(0));
      check("t6_rst_coal", line_t'(stat_coalesces), line_t'(0));
      check("t6_rst_hwm", line_t'(stat_hwm), line_t'(0));
`endif
      rst = 1'b0;
      tick(); tick();
      check("t6_post_empty", line_t'(empty), line_t'(1));
      check("t6_post_req", line_t'(mem_req), line_t'(0));
      snoop_valid = 1'b1; snoop_addr = 32'h100;
      #1;
      check("t6_post_snoop", line_t'(snoop_hit), line_t'(0));
      snoop_valid = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/wb_buffer.md
Name: wb_buffer

Overview:
- Per-cache writeback buffer, one instance per cache, sitting directly downstream of the cache.
- Accepts dirty-line evictions from the cache and drains them in order to memory with a req/ack handshake.
- Coalesces repeat evictions of the same line.
- Answers snoop lookups so a line in transit is never lost to a bus reader.

Parameters:
- DEPTH, 4: number of line entries; power of two, minimum 2.
- ID, 0: owning cache index; used only in assertion messages.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- push_valid  in  1  cache presents an evicted dirty line
- push_ready  out  1  buffer accepts the line this cycle
- push_addr  in  XLEN  line address
- push_data  in  CACHELINE_SIZE  line data
- mem_req  out  1  write request to memory
- mem_addr  out  XLEN  head entry address
- mem_wdata  out  CACHELINE_SIZE  head entry data
- mem_ack  in  1  memory write complete; single-cycle pulse
- snoop_valid  in  1  bus transaction lookup
- snoop_addr  in  XLEN  snooped address
- snoop_hit  out  1  line is pending in the buffer
- snoop_data  out  CACHELINE_SIZE  youngest pending copy of the line
- count  out  $clog2(DEPTH)+1  occupancy
- empty  out  1  count==0

Behaviour:
- Reset values: all entries invalid; head=tail=0; count=0; empty=1; mem_req=0; mem_addr=0; mem_wdata=0; snoop_hit=0; snoop_data=0; drain FSM in IDLE.
- Address matching: compare line addresses only, i.e. XLEN bits above LINE_OFFSET_BITS.
- Storage: circular FIFO.
  - head/tail pointers are $clog2(DEPTH) bits and wrap naturally.
  - count is tracked separately, so full and empty are unambiguous.
- Coalesce condition: push_addr matches a valid entry that is not the head while the FSM is in ISSUE.
  - On push_valid&&push_ready, that entry's data is overwritten in place.
  - count, tail and order are unchanged.
- Allocation: with no coalesce match, the line is written at tail; tail+1, count+1.
- push_ready = (count<DEPTH) || coalesce_match. Combinational from registered state plus push_addr.
- Drain FSM, two states:
  - IDLE -> ISSUE when count>0.
  - ISSUE: mem_req=1; mem_addr/mem_wdata driven from the head entry and held stable until mem_ack.
  - On mem_ack: pop head (head+1, count-1). Go to ISSUE if count-1>0, else IDLE. Back-to-back issue carries no bubble.
  - mem_ack while in IDLE is ignored; this case is flagged by an assertion.
- Simultaneous push and pop:
  - Both take effect; count is unchanged.
  - A push matching the head being popped allocates a new entry; it never coalesces into the popping head.
- Full: push_ready=0 unless coalescing; the cache must stall. A pop frees space visible in the next cycle.
- Snoop (combinational):
  - snoop_hit = snoop_valid && any valid entry matches.
  - snoop_data = data of the youngest matching entry; at most two matches can exist (in-flight head plus a newer copy).
  - Lookup reflects registered contents only; a same-cycle push is not visible.
  - Snoop never blocks or modifies the drain.
- Reset mid-drain: all pending entries are discarded and mem_req drops in the next cycle.
- Latency:
  - Push into an empty, IDLE buffer -> mem_req high 2 cycles later (write at cycle 0, FSM to ISSUE at cycle 1, mem_req visible from cycle 2 registered outputs).
  - Minimum occupancy of one entry is 2 cycles + memory latency.

Optional Feature:
- Macro: WB_BUFFER_STATS_EN.
- Defined: adds outputs stat_pushes (32b, accepted pushes), stat_coalesces (32b) and stat_hwm ($clog2(DEPTH)+1, occupancy high-water mark).
  - All three reset to 0; the two 32b counters wrap.
- Undefined: these ports and registers do not exist; function is otherwise identical.

Decomposition:
- Package types: LINE_OFFSET_BITS = $clog2(CACHELINE_SIZE/8); wb_entry_t {valid, addr[XLEN], data[CACHELINE_SIZE]}; wb_state_t {WB_IDLE, WB_ISSUE}.
- XLEN and CACHELINE_SIZE come from the same package.
- One natural sub-module: wb_match, a combinational youngest-first address CAM over DEPTH entries. It is shared by the coalesce lookup and the snoop lookup (two instances).

Test Plan:
- Single drain: push A=0x100/D1 with mem_ack 3 cycles after mem_req -> mem_req with mem_addr=0x100, mem_wdata=D1 held until ack; then empty=1, mem_req=0.
- Fill and stall: hold mem_ack low; push 0x100, 0x140, 0x180, 0x1C0 (DEPTH=4) -> count=4, push_ready=0 for new 0x200. After one mem_ack, 0x200 is accepted the next cycle and drain order is 0x100..0x200.
- Coalesce: push 0x140/D1 behind in-flight 0x100, then 0x140/D2 -> count stays 2; drained data for 0x140 is D2. A re-push of 0x100 while it is in flight allocates a new entry (count=3).
- Snoop: pending 0x180/D3; snoop_valid with addr 0x184 -> snoop_hit=1, snoop_data=D3 in the same cycle. Snoop of 0x200 -> snoop_hit=0.
- Push and ack in the same cycle at count=4 with a coalescing address -> push accepted, count=3.
- Reset mid-drain: rst asserted with count=3 and mem_req=1 -> next cycle count=0, mem_req=0, and the FIFO is empty after rst deasserts. With WB_BUFFER_STATS_EN, counters read 0.
